// File: rtl/avalon_streaming_fifo.sv
// Avalon-ST packet FIFO with show-ahead output, level/almost-full reporting,
// synchronous flush and a sticky sop/eop framing error flag.
module avalon_streaming_fifo #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 10,
  parameter int unsigned ALMOST_FULL = DEPTH - 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         asi_valid,
  input  logic [DATA_WIDTH-1:0]        asi_data,
  input  logic                         asi_startofpacket,
  input  logic                         asi_endofpacket,
  output logic                         asi_ready,
  output logic                         aso_valid,
  output logic [DATA_WIDTH-1:0]        aso_data,
  output logic                         aso_startofpacket,
  output logic                         aso_endofpacket,
  input  logic                         aso_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full,
  output logic                         proto_err
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = DATA_WIDTH + 2;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [LW-1:0] level_next;
  logic          ready_en, in_pkt, in_pkt_next, err_set;
  logic          push, pop;

  // Handshakes; flush suppresses both sides for the cycle.
  assign asi_ready = ready_en && (level < LW'(DEPTH));
  assign aso_valid = (level != '0);
  assign push      = asi_valid && asi_ready && !flush;
  assign pop       = aso_valid && aso_ready && !flush;

  // Show-ahead head word, zeroed while empty.
  assign head = mem[rd_ptr];
  assign {aso_data, aso_startofpacket, aso_endofpacket} = aso_valid ? head : '0;

  always_comb begin
    level_next  = level;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    in_pkt_next = in_pkt;
    err_set     = 1'b0;
    if (flush) begin
      level_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push) wr_ptr_next = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr_next = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (push && !pop) level_next = level + LW'(1);
      if (pop && !push) level_next = level - LW'(1);
    end
    // Framing: sop opens a packet, eop closes it (sop+eop leaves it closed).
    if (push) begin
      err_set     = (asi_startofpacket && in_pkt) || (!asi_startofpacket && !in_pkt);
      in_pkt_next = asi_endofpacket ? 1'b0 : (asi_startofpacket ? 1'b1 : in_pkt);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en    <= 1'b0;
      level       <= '0;
      almost_full <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      in_pkt      <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      ready_en    <= 1'b1;
      level       <= level_next;
      almost_full <= (level_next >= LW'(ALMOST_FULL));
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      in_pkt      <= in_pkt_next;
      proto_err   <= proto_err | err_set;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {asi_data, asi_startofpacket, asi_endofpacket};
  end

endmodule

// File: tb/tb_avalon_streaming_fifo.sv
// Directed bench for avalon_streaming_fifo at DATA_WIDTH=8, DEPTH=10.
module tb_avalon_streaming_fifo;

  logic       clk, reset;
  logic       asi_valid, asi_startofpacket, asi_endofpacket, asi_ready;
  logic [7:0] asi_data, aso_data;
  logic       aso_valid, aso_startofpacket, aso_endofpacket, aso_ready;
  logic       flush, almost_full, proto_err;
  logic [3:0] level;

  int errors = 0;
  int checks = 0;

  avalon_streaming_fifo #(.DATA_WIDTH(8), .DEPTH(10)) dut (
    .clk(clk), .reset(reset),
    .asi_valid(asi_valid), .asi_data(asi_data),
    .asi_startofpacket(asi_startofpacket), .asi_endofpacket(asi_endofpacket),
    .asi_ready(asi_ready),
    .aso_valid(aso_valid), .aso_data(aso_data),
    .aso_startofpacket(aso_startofpacket), .aso_endofpacket(aso_endofpacket),
    .aso_ready(aso_ready),
    .flush(flush), .level(level), .almost_full(almost_full), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d, input logic sop, input logic eop);
    asi_valid = 1'b1; asi_data = d; asi_startofpacket = sop; asi_endofpacket = eop;
    tick();
    asi_valid = 1'b0; asi_startofpacket = 1'b0; asi_endofpacket = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (asi_ready !== 1'b0) begin errors++; $display("FAIL rst_asi_ready got %b exp 0", asi_ready); end
    checks++; if (aso_valid !== 1'b0) begin errors++; $display("FAIL rst_aso_valid got %b exp 0", aso_valid); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level); end
    checks++; if ({almost_full, proto_err} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b exp 00", {almost_full, proto_err}); end
    reset = 1'b1;
    #2;
    checks++; if (asi_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_before_edge got %b exp 0", asi_ready); end
    tick();
    checks++; if (asi_ready !== 1'b1) begin errors++; $display("FAIL rel_ready_after_edge got %b exp 1", asi_ready); end
    checks++; if (aso_valid !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL rel_empty got valid=%b level=%0d exp 0/0", aso_valid, level); end
  endtask

  task automatic test_order();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    aso_ready = 1'b0;
    push_word(8'h11, 1'b1, 1'b1);
    checks++; if (aso_valid !== 1'b1 || aso_data !== 8'h11) begin errors++; $display("FAIL showahead got valid=%b data=%h exp 1/11", aso_valid, aso_data); end
    push_word(8'h22, 1'b1, 1'b1);
    push_word(8'h33, 1'b1, 1'b1);
    checks++; if (level !== 4'd3 || aso_data !== 8'h11) begin errors++; $display("FAIL order_hold got level=%0d data=%h exp 3/11", level, aso_data); end
    aso_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (aso_valid !== 1'b1 || aso_data !== exp_d[i]) begin errors++; $display("FAIL order_pop%0d got valid=%b data=%h exp 1/%h", i, aso_valid, aso_data, exp_d[i]); end
      tick();
      checks++; if (level !== 4'(2 - i)) begin errors++; $display("FAIL order_level%0d got %0d exp %0d", i, level, 2 - i); end
    end
    checks++; if (aso_valid !== 1'b0 || aso_data !== 8'h00) begin errors++; $display("FAIL order_empty got valid=%b data=%h exp 0/00", aso_valid, aso_data); end
    aso_ready = 1'b0;
  endtask

  task automatic test_full();
    for (int k = 0; k < 10; k++) begin
      push_word(8'(8'h40 + k), 1'b1, 1'b1);
      checks++; if (level !== 4'(k + 1) || almost_full !== (k + 1 >= 8)) begin errors++; $display("FAIL fill%0d got level=%0d af=%b exp %0d/%b", k, level, almost_full, k + 1, (k + 1 >= 8)); end
    end
    checks++; if (asi_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", asi_ready); end
    push_word(8'hEE, 1'b1, 1'b1);
    checks++; if (level !== 4'd10) begin errors++; $display("FAIL full_blocked got level=%0d exp 10", level); end
    aso_ready = 1'b1;
    checks++; if (aso_data !== 8'h40 || asi_ready !== 1'b0) begin errors++; $display("FAIL full_head got data=%h ready=%b exp 40/0", aso_data, asi_ready); end
    tick();
    aso_ready = 1'b0;
    checks++; if (level !== 4'd9 || asi_ready !== 1'b1 || almost_full !== 1'b1) begin errors++; $display("FAIL full_pop got level=%0d ready=%b af=%b exp 9/1/1", level, asi_ready, almost_full); end
    checks++; if (aso_data !== 8'h41) begin errors++; $display("FAIL full_next got %h exp 41", aso_data); end
    aso_ready = 1'b1;
    repeat (9) tick();
    aso_ready = 1'b0;
    checks++; if (level !== 4'd0 || almost_full !== 1'b0) begin errors++; $display("FAIL full_drain got level=%0d af=%b exp 0/0", level, almost_full); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) push_word(8'(8'h50 + k), 1'b1, 1'b1);
    checks++; if (level !== 4'd5) begin errors++; $display("FAIL b2b_prefill got %0d exp 5", level); end
    aso_ready = 1'b1; asi_valid = 1'b1; asi_startofpacket = 1'b1; asi_endofpacket = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++; if (aso_data !== 8'(8'h50 + i)) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", i, aso_data, 8'(8'h50 + i)); end
      asi_data = 8'(8'h55 + i);
      tick();
      checks++; if (level !== 4'd5) begin errors++; $display("FAIL b2b_level%0d got %0d exp 5", i, level); end
    end
    asi_valid = 1'b0; asi_startofpacket = 1'b0; asi_endofpacket = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (aso_data !== 8'(8'h64 + i)) begin errors++; $display("FAIL b2b_tail%0d got %h exp %h", i, aso_data, 8'(8'h64 + i)); end
      tick();
    end
    aso_ready = 1'b0;
    checks++; if (level !== 4'd0 || aso_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got level=%0d valid=%b exp 0/0", level, aso_valid); end
  endtask

  task automatic test_framing();
    push_word(8'hA0, 1'b1, 1'b0);
    push_word(8'hA1, 1'b0, 1'b0);
    push_word(8'hA2, 1'b0, 1'b1);
    push_word(8'hB0, 1'b1, 1'b0);
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL frame_clean got %b exp 0", proto_err); end
    checks++; if (aso_startofpacket !== 1'b1 || aso_endofpacket !== 1'b0) begin errors++; $display("FAIL frame_sideband got sop=%b eop=%b exp 1/0", aso_startofpacket, aso_endofpacket); end
    push_word(8'hB1, 1'b1, 1'b0);
    checks++; if (proto_err !== 1'b1 || level !== 4'd5) begin errors++; $display("FAIL frame_err got err=%b level=%0d exp 1/5", proto_err, level); end
    flush = 1'b1; asi_valid = 1'b1; asi_data = 8'hCC; aso_ready = 1'b1;
    tick();
    flush = 1'b0; asi_valid = 1'b0; aso_ready = 1'b0;
    checks++; if (level !== 4'd0 || aso_valid !== 1'b0 || aso_data !== 8'h00) begin errors++; $display("FAIL flush_empty got level=%0d valid=%b data=%h exp 0/0/00", level, aso_valid, aso_data); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL flush_err_sticky got %b exp 1", proto_err); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 6; k++) push_word(8'(8'h70 + k), 1'b1, 1'b1);
    checks++; if (level !== 4'd6) begin errors++; $display("FAIL mid_prefill got %0d exp 6", level); end
    reset = 1'b0;
    #2;
    checks++; if ({asi_ready, aso_valid, aso_startofpacket, aso_endofpacket} !== 4'b0000 || aso_data !== 8'h00) begin errors++; $display("FAIL mid_rst_outputs got rdy=%b v=%b sop=%b eop=%b d=%h exp all 0", asi_ready, aso_valid, aso_startofpacket, aso_endofpacket, aso_data); end
    checks++; if (level !== 4'd0 || almost_full !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL mid_rst_state got level=%0d af=%b err=%b exp 0/0/0", level, almost_full, proto_err); end
    tick();
    reset = 1'b1;
    tick();
    checks++; if (asi_ready !== 1'b1 || level !== 4'd0) begin errors++; $display("FAIL mid_release got ready=%b level=%0d exp 1/0", asi_ready, level); end
    push_word(8'hA5, 1'b1, 1'b1);
    checks++; if (aso_valid !== 1'b1 || aso_data !== 8'hA5 || level !== 4'd1) begin errors++; $display("FAIL mid_first got valid=%b data=%h level=%0d exp 1/a5/1", aso_valid, aso_data, level); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL mid_err got %b exp 0", proto_err); end
    aso_ready = 1'b1;
    tick();
    aso_ready = 1'b0;
    checks++; if (aso_valid !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL mid_only got valid=%b level=%0d exp 0/0", aso_valid, level); end
  endtask

  initial begin
    reset = 1'b0; asi_valid = 1'b0; asi_data = 8'h00;
    asi_startofpacket = 1'b0; asi_endofpacket = 1'b0;
    aso_ready = 1'b0; flush = 1'b0;
    tick();
    tick();
    test_reset();
    test_order();
    test_full();
    test_back_to_back();
    test_framing();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/avalon_streaming_fifo.md
AVALON_STREAMING_FIFO -- requirements
Module: avalon_streaming_fifo

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the width in bits of asi_data and aso_data (legal range 1 to 64).
REQ-003 Parameter DEPTH, default 10, SHALL set the number of entries (legal range 2 to 1024, not required to be a power of two).
REQ-004 Parameter ALMOST_FULL, default DEPTH-2, SHALL set the level threshold for almost_full (legal range 1 to DEPTH).
REQ-005 Port clk, input, 1 bit: rising-edge clock.
REQ-006 Port reset, input, 1 bit: asynchronous active-low reset.
REQ-007 Port asi_valid, input, 1 bit: sink word valid.
REQ-008 Port asi_data, input, DATA_WIDTH bits: sink data.
REQ-009 Port asi_startofpacket, input, 1 bit: sink first word of packet.
REQ-010 Port asi_endofpacket, input, 1 bit: sink last word of packet.
REQ-011 Port asi_ready, output, 1 bit: sink ready, ready latency 0.
REQ-012 Port aso_valid, output, 1 bit: source word valid.
REQ-013 Port aso_data, output, DATA_WIDTH bits: source data.
REQ-014 Port aso_startofpacket, output, 1 bit: source first word of packet.
REQ-015 Port aso_endofpacket, output, 1 bit: source last word of packet.
REQ-016 Port aso_ready, input, 1 bit: source ready.
REQ-017 Port flush, input, 1 bit: synchronous discard of all contents.
REQ-018 Port level, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-019 Port almost_full, output, 1 bit: asserted when level >= ALMOST_FULL.
REQ-020 Port proto_err, output, 1 bit: sticky packet-framing error flag.

Function
REQ-021 Each entry SHALL store {data, sop, eop}, written at wr_ptr and read at rd_ptr.
- Both pointers SHALL wrap from DEPTH-1 to 0.
REQ-022 A push SHALL occur on a rising edge with asi_valid && asi_ready; a pop SHALL occur on a rising edge with aso_valid && aso_ready.
REQ-023 Level SHALL update per edge as follows:
- push only: +1.
- pop only: -1.
- push and pop together: unchanged, with both pointers advancing.
REQ-024 asi_ready SHALL equal ready_en && (level < DEPTH).
- ready_en is a register cleared by reset and set on the first rising edge after reset deasserts.
- A push when full is therefore impossible; when full, a pop frees space visible on the next cycle only.
REQ-025 aso_valid SHALL equal (level > 0).
- The output is show-ahead: a word pushed at edge N into an empty FIFO SHALL be presented with aso_valid=1 in the cycle after edge N.
REQ-026 While aso_valid=0, aso_data, aso_startofpacket and aso_endofpacket SHALL be driven to 0.
- While aso_valid=1, they SHALL be the entry at rd_ptr.
REQ-027 aso_valid, aso_data and the sideband signals SHALL hold stable while aso_valid && !aso_ready.
REQ-028 When flush=1 at an edge, the block SHALL zero level, wr_ptr and rd_ptr, and SHALL ignore any push or pop in that same cycle.
- proto_err and the packet-tracking state SHALL be unaffected by flush.
REQ-029 Framing check on accepted pushes: an in_pkt register SHALL be set by sop and cleared by eop; a single-word packet (sop=1, eop=1) leaves in_pkt=0.
REQ-030 proto_err SHALL set on the edge of an accepted push with sop=1 while in_pkt=1, or with sop=0 while in_pkt=0.
- The word SHALL still be stored.
- proto_err SHALL clear only on reset.
REQ-031 level and almost_full SHALL be registered, reflecting state after the most recent edge.

Reset
REQ-032 While reset=0, the block SHALL hold:
- asi_ready=0, aso_valid=0, aso_data=0, aso_startofpacket=0, aso_endofpacket=0.
- level=0, almost_full=0, proto_err=0.
- pointers=0, in_pkt=0, ready_en=0.
REQ-033 Reset asserted mid-operation SHALL discard all stored words immediately, with no pop or push completing on that edge.
- Storage array contents need not be cleared.

Verification
REQ-034 Reset release, DATA_WIDTH=8, DEPTH=10: asi_ready=0 until the first edge, then 1; aso_valid=0; level=0.
REQ-035 Push 0x11, 0x22, 0x33 with aso_ready=0, then aso_ready=1: output is 0x11, 0x22, 0x33 in order; level goes 3->0; aso_valid drops after the third pop.
REQ-036 Fill with 10 words: level=10, asi_ready=0, almost_full=1 from level 8; one pop gives level=9 and asi_ready=1 the next cycle.
REQ-037 Simultaneous push and pop at level 5 across 20 cycles: level stays 5, pointers wrap past 9, data order is preserved.
REQ-038 Packet sequence sop/eop framing, then sop while in_pkt=1: proto_err=1 after that edge and stays 1 through a flush; flush gives level=0 and aso_valid=0.
REQ-039 Reset asserted with level=6: all outputs reach reset values without a clock; after release, first push 0xA5 emerges as the only word.
